ace_trs_route: RTL

ACE_TRS_ROUTE -- requirements
Module: ace_trs_route

---
 rtl/ace_trs_route.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ace_trs_route.sv
// ACE AW/AR snoop router: flags each beat for the CCU or bypass and passes it through a one-entry slice per channel.
// Latency 1 cycle at full throughput; x_ready_o = !x_valid_o || x_ready_i, with no combinational path from x_valid_i.
package ace_trs_route_pkg;
    typedef struct packed {
        logic [2:0] snoop;
        logic [1:0] domain;
        logic [1:0] bar;
    } ace_aw_chan_t;

    typedef struct packed {
        logic [3:0] snoop;
        logic [1:0] domain;
        logic [1:0] bar;
    } ace_ar_chan_t;
endpackage

module ace_trs_route #(
    parameter logic        AwSnoopEn = 1'b1,
    parameter int unsigned CntWidth  = 16,
    parameter type         aw_chan_t = ace_trs_route_pkg::ace_aw_chan_t,
    parameter type         ar_chan_t = ace_trs_route_pkg::ace_ar_chan_t
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                aw_valid_i,
    output logic                aw_ready_o,
    input  aw_chan_t            aw_i,
    output logic                aw_valid_o,
    input  logic                aw_ready_i,
    output aw_chan_t            aw_o,
    output logic                aw_snoop_o,
    input  logic                ar_valid_i,
    output logic                ar_ready_o,
    input  ar_chan_t            ar_i,
    output logic                ar_valid_o,
    input  logic                ar_ready_i,
    output ar_chan_t            ar_o,
    output logic                ar_snoop_o,
    output logic [CntWidth-1:0] aw_snp_cnt_o,
    output logic [CntWidth-1:0] aw_byp_cnt_o,
    output logic [CntWidth-1:0] ar_snp_cnt_o,
    output logic [CntWidth-1:0] ar_byp_cnt_o
);
    localparam logic [CntWidth-1:0] CntMax = '1;

    logic                aw_valid_q, aw_valid_d, aw_snp_q, aw_snp_d;
    aw_chan_t            aw_dat_q, aw_dat_d;
    logic                ar_valid_q, ar_valid_d, ar_snp_q, ar_snp_d;
    ar_chan_t            ar_dat_q, ar_dat_d;
    logic [CntWidth-1:0] aw_snp_cnt_q, aw_snp_cnt_d, aw_byp_cnt_q, aw_byp_cnt_d;
    logic [CntWidth-1:0] ar_snp_cnt_q, ar_snp_cnt_d, ar_byp_cnt_q, ar_byp_cnt_d;
    logic                aw_write_back, aw_write_nosnp, aw_snp_flag, ar_read_nosnp;
    logic                aw_in_hs, aw_out_hs, ar_in_hs, ar_out_hs;

    // Saturating increment; clear wins over a coincident increment.
    function automatic logic [CntWidth-1:0] cnt_next(logic [CntWidth-1:0] cnt, logic inc, logic clr);
        if (clr) begin
            return '0;
        end
        if (inc && (cnt != CntMax)) begin
            return cnt + CntWidth'(1);
        end
        return cnt;
    endfunction

    assign aw_ready_o = !aw_valid_q || aw_ready_i;
    assign ar_ready_o = !ar_valid_q || ar_ready_i;

    always_comb begin
        // A barrier (bar[0]=1) never matches a bypass class.
        aw_write_back  = (aw_i.snoop == 3'b011) && !aw_i.bar[0] && (aw_i.domain != 2'b11);
        aw_write_nosnp = (aw_i.snoop == 3'b000) && !aw_i.bar[0] &&
                         ((aw_i.domain == 2'b00) || (aw_i.domain == 2'b11));
        aw_snp_flag    = AwSnoopEn && !(aw_write_back || aw_write_nosnp);
        ar_read_nosnp  = (ar_i.snoop == 4'b0000) && !ar_i.bar[0] &&
                         ((ar_i.domain == 2'b00) || (ar_i.domain == 2'b11));

        aw_in_hs  = aw_valid_i && aw_ready_o;
        aw_out_hs = aw_valid_q && aw_ready_i;
        ar_in_hs  = ar_valid_i && ar_ready_o;
        ar_out_hs = ar_valid_q && ar_ready_i;

        aw_valid_d = aw_in_hs || (aw_valid_q && !aw_out_hs);
        aw_dat_d   = aw_in_hs ? aw_i : aw_dat_q;
        aw_snp_d   = aw_in_hs ? aw_snp_flag : aw_snp_q;
        ar_valid_d = ar_in_hs || (ar_valid_q && !ar_out_hs);
        ar_dat_d   = ar_in_hs ? ar_i : ar_dat_q;
        ar_snp_d   = ar_in_hs ? !ar_read_nosnp : ar_snp_q;

        aw_snp_cnt_d = cnt_next(aw_snp_cnt_q, aw_out_hs && aw_snp_q, clr_i);
        aw_byp_cnt_d = cnt_next(aw_byp_cnt_q, aw_out_hs && !aw_snp_q, clr_i);
        ar_snp_cnt_d = cnt_next(ar_snp_cnt_q, ar_out_hs && ar_snp_q, clr_i);
        ar_byp_cnt_d = cnt_next(ar_byp_cnt_q, ar_out_hs && !ar_snp_q, clr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_valid_q   <= 1'b0;
            aw_dat_q     <= '0;
            aw_snp_q     <= 1'b0;
            ar_valid_q   <= 1'b0;
            ar_dat_q     <= '0;
            ar_snp_q     <= 1'b0;
            aw_snp_cnt_q <= '0;
            aw_byp_cnt_q <= '0;
            ar_snp_cnt_q <= '0;
            ar_byp_cnt_q <= '0;
        end else begin
            aw_valid_q   <= aw_valid_d;
            aw_dat_q     <= aw_dat_d;
            aw_snp_q     <= aw_snp_d;
            ar_valid_q   <= ar_valid_d;
            ar_dat_q     <= ar_dat_d;
            ar_snp_q     <= ar_snp_d;
            aw_snp_cnt_q <= aw_snp_cnt_d;
            aw_byp_cnt_q <= aw_byp_cnt_d;
            ar_snp_cnt_q <= ar_snp_cnt_d;
            ar_byp_cnt_q <= ar_byp_cnt_d;
        end
    end

    assign aw_valid_o   = aw_valid_q;
    assign aw_o         = aw_dat_q;
    assign aw_snoop_o   = aw_snp_q;
    assign ar_valid_o   = ar_valid_q;
    assign ar_o         = ar_dat_q;
    assign ar_snoop_o   = ar_snp_q;
    assign aw_snp_cnt_o = aw_snp_cnt_q;
    assign aw_byp_cnt_o = aw_byp_cnt_q;
    assign ar_snp_cnt_o = ar_snp_cnt_q;
    assign ar_byp_cnt_o = ar_byp_cnt_q;
endmodule
